// File: rtl/piso_ctrl.sv
// piso_ctrl: sequencing controller for a W-stage parallel-in/serial-out chain.
//
// Accepts a parallel word on a valid/ready handshake, holds it on the chain's
// parallel inputs, strobes a one-cycle load, then shifts the chain one stage
// per accepted serial beat. The serial stream is framed with valid/last under
// downstream back-pressure. An optional idle gap follows each word.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   in_valid/in_data       producer word (bit W-1 serialized first)
//   in_ready               controller is idle and will take a word
//   flush                  synchronous abort of the word in flight
//   piso_data              held word driving the chain parallel inputs
//   piso_uptake            chain load strobe
//   piso_enable            chain shift strobe
//   piso_out               chain serial output (monitored, passed through)
//   ser_data/ser_valid     serial bit and its qualifier
//   ser_ready              downstream accepts the current bit
//   ser_last               current bit is bit 0 of the word
//   busy                   controller is not idle
module piso_ctrl #(
    parameter int W          = 6,
    parameter int GAP_CYCLES = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    input  logic         flush,
    output logic [W-1:0] piso_data,
    output logic         piso_uptake,
    output logic         piso_enable,
    input  logic         piso_out,
    output logic         ser_data,
    output logic         ser_valid,
    input  logic         ser_ready,
    output logic         ser_last,
    output logic         busy
);

    localparam int             CW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0]  LAST_BIT = CW'(W - 1);
    // Only consulted in GAP, which is unreachable when GAP_CYCLES is 0.
    localparam logic [3:0]     GAP_LAST = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] bit_cnt, bit_cnt_nxt;
    logic [3:0]    gap_cnt, gap_cnt_nxt;
    logic          capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            gap_cnt <= gap_cnt_nxt;
        end
    end

    // The word stays on the chain inputs until the next accepted handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       piso_data <= '0;
        else if (capture) piso_data <= in_data;
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        gap_cnt_nxt = gap_cnt;
        capture     = 1'b0;
        in_ready    = 1'b0;
        piso_uptake = 1'b0;
        piso_enable = 1'b0;
        ser_valid   = 1'b0;
        ser_last    = 1'b0;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    capture   = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                piso_uptake = 1'b1;
                bit_cnt_nxt = '0;
                state_nxt   = SHIFT;
            end
            SHIFT: begin
                // Chain output already presents piso_data[W-1-bit_cnt];
                // a stall simply withholds the shift strobe.
                ser_valid   = 1'b1;
                ser_last    = (bit_cnt == LAST_BIT);
                piso_enable = ser_ready;
                if (ser_ready) begin
                    if (ser_last) begin
                        gap_cnt_nxt = '0;
                        state_nxt   = (GAP_CYCLES > 0) ? GAP : IDLE;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_cnt_nxt = '0;
                    state_nxt   = IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Abort wins over everything, including a pending capture in IDLE.
        if (flush) begin
            state_nxt   = IDLE;
            bit_cnt_nxt = '0;
            gap_cnt_nxt = '0;
            capture     = 1'b0;
        end
    end

    assign busy     = (state != IDLE);
    assign ser_data = piso_out;

endmodule

// File: tb/tb_piso_ctrl.sv
// Self-checking bench for piso_ctrl: per-cycle vector table for the basic,
// stalled and back-to-back streams, then hand-written flush, async reset and
// inter-word gap sequences. A behavioural 6-stage chain closes the loop.
module tb_piso_ctrl;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, flush, ser_ready;
    logic [W-1:0] in_data;
    logic         in_ready, piso_uptake, piso_enable, piso_out;
    logic         ser_data, ser_valid, ser_last, busy;
    logic [W-1:0] piso_data;

    logic         g_in_valid, g_flush, g_ser_ready;
    logic [W-1:0] g_in_data;
    logic         g_in_ready, g_piso_uptake, g_piso_enable, g_piso_out;
    logic         g_ser_data, g_ser_valid, g_ser_last, g_busy;
    logic [W-1:0] g_piso_data;

    logic [W-1:0] chain, g_chain;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    piso_ctrl #(.W(W), .GAP_CYCLES(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .flush(flush), .piso_data(piso_data),
        .piso_uptake(piso_uptake), .piso_enable(piso_enable), .piso_out(piso_out),
        .ser_data(ser_data), .ser_valid(ser_valid), .ser_ready(ser_ready),
        .ser_last(ser_last), .busy(busy)
    );

    piso_ctrl #(.W(W), .GAP_CYCLES(3)) dut_gap (
        .clk(clk), .rst_n(rst_n), .in_valid(g_in_valid), .in_data(g_in_data),
        .in_ready(g_in_ready), .flush(g_flush), .piso_data(g_piso_data),
        .piso_uptake(g_piso_uptake), .piso_enable(g_piso_enable), .piso_out(g_piso_out),
        .ser_data(g_ser_data), .ser_valid(g_ser_valid), .ser_ready(g_ser_ready),
        .ser_last(g_ser_last), .busy(g_busy)
    );

    // Behavioural shift chains: load on uptake, shift toward the MSB with
    // zero fill on enable, serial output is the MSB stage.
    always_ff @(posedge clk) begin
        if (piso_uptake)      chain <= piso_data;
        else if (piso_enable) chain <= {chain[W-2:0], 1'b0};
        if (g_piso_uptake)      g_chain <= g_piso_data;
        else if (g_piso_enable) g_chain <= {g_chain[W-2:0], 1'b0};
    end
    assign piso_out   = chain[W-1];
    assign g_piso_out = g_chain[W-1];

    typedef struct {
        logic         iv;
        logic [W-1:0] id;
        logic         fl;
        logic         sr;
        logic         e_ir, e_busy, e_up, e_en, e_sv, e_sd, e_sl;
        logic [W-1:0] e_pd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t row(logic iv, logic [W-1:0] id, logic fl, logic sr,
                                 logic ir, logic bz, logic up, logic en,
                                 logic sv, logic sd, logic sl, logic [W-1:0] pd);
        vec_t v;
        v.iv = iv; v.id = id; v.fl = fl; v.sr = sr;
        v.e_ir = ir; v.e_busy = bz; v.e_up = up; v.e_en = en;
        v.e_sv = sv; v.e_sd = sd; v.e_sl = sl; v.e_pd = pd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [W-1:0] id, input logic fl, input logic sr);
        in_valid = iv; in_data = id; flush = fl; ser_ready = sr;
    endtask

    // Expects the DUT to be in its first SHIFT cycle with ser_ready=1.
    task automatic serial_check(input logic [W-1:0] w, input string tag);
        for (int b = W - 1; b >= 0; b--) begin
            @(negedge clk);
            chk({tag, "_sv"}, ser_valid, 1'b1);
            chk({tag, "_sd"}, ser_data, w[b]);
            chk({tag, "_sl"}, ser_last, (b == 0));
            tick();
        end
        @(negedge clk);
        chk({tag, "_ir_after"}, in_ready, 1'b1);
        chk({tag, "_sv_after"}, ser_valid, 1'b0);
    endtask

    initial begin
        logic [W-1:0] wa, wb, wc;
        wa = 6'b101100;
        wb = 6'h3F;
        wc = 6'h15;

        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b1);
        g_in_valid = 1'b0; g_in_data = '0; g_flush = 1'b0; g_ser_ready = 1'b1;
        repeat (2) @(posedge clk);

        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_uptake", piso_uptake, 1'b0);
        chk("rst_enable", piso_enable, 1'b0);
        chk("rst_ser_valid", ser_valid, 1'b0);
        chk("rst_ser_last", ser_last, 1'b0);
        chk("rst_piso_data", piso_data, '0);
        rst_n = 1'b1;
        tick();

        // Word 1: plain stream.
        vecs.push_back(row(1, wa, 0, 1, 1, 0, 1'b0, 0, 0, 0, 0, '0));
        vecs.push_back(row(0, wa, 0, 1, 0, 1, 1'b1, 0, 0, 0, 0, wa));
        for (int b = W - 1; b >= 0; b--)
            vecs.push_back(row(0, '0, 0, 1, 0, 1, 0, 1, 1, wa[b], b == 0, wa));
        vecs.push_back(row(0, '0, 0, 1, 1, 0, 0, 0, 0, 0, 0, wa));
        // Word 2: same word, 3 stall cycles after the 2nd bit.
        vecs.push_back(row(1, wa, 0, 1, 1, 0, 0, 0, 0, 0, 0, wa));
        vecs.push_back(row(0, '0, 0, 1, 0, 1, 1, 0, 0, 0, 0, wa));
        vecs.push_back(row(0, '0, 0, 1, 0, 1, 0, 1, 1, 1, 0, wa));
        vecs.push_back(row(0, '0, 0, 1, 0, 1, 0, 1, 1, 0, 0, wa));
        for (int k = 0; k < 3; k++)
            vecs.push_back(row(0, '0, 0, 0, 0, 1, 0, 0, 1, 1, 0, wa));
        vecs.push_back(row(0, '0, 0, 1, 0, 1, 0, 1, 1, 1, 0, wa));
        vecs.push_back(row(0, '0, 0, 1, 0, 1, 0, 1, 1, 1, 0, wa));
        vecs.push_back(row(0, '0, 0, 1, 0, 1, 0, 1, 1, 0, 0, wa));
        vecs.push_back(row(0, '0, 0, 1, 0, 1, 0, 1, 1, 0, 1, wa));
        // Words 3/4: back-to-back with in_valid held.
        vecs.push_back(row(1, wb, 0, 1, 1, 0, 0, 0, 0, 0, 0, wa));
        vecs.push_back(row(1, wc, 0, 1, 0, 1, 1, 0, 0, 0, 0, wb));
        for (int b = W - 1; b >= 0; b--)
            vecs.push_back(row(1, wc, 0, 1, 0, 1, 0, 1, 1, wb[b], b == 0, wb));
        vecs.push_back(row(1, wc, 0, 1, 1, 0, 0, 0, 0, 0, 0, wb));
        vecs.push_back(row(0, '0, 0, 1, 0, 1, 1, 0, 0, 0, 0, wc));
        for (int b = W - 1; b >= 0; b--)
            vecs.push_back(row(0, '0, 0, 1, 0, 1, 0, 1, 1, wc[b], b == 0, wc));
        vecs.push_back(row(0, '0, 0, 1, 1, 0, 0, 0, 0, 0, 0, wc));

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].id, vecs[i].fl, vecs[i].sr);
            @(negedge clk);
            chk($sformatf("v%0d_in_ready", i), in_ready, vecs[i].e_ir);
            chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
            chk($sformatf("v%0d_uptake", i), piso_uptake, vecs[i].e_up);
            chk($sformatf("v%0d_enable", i), piso_enable, vecs[i].e_en);
            chk($sformatf("v%0d_ser_valid", i), ser_valid, vecs[i].e_sv);
            chk($sformatf("v%0d_ser_last", i), ser_last, vecs[i].e_sl);
            chk($sformatf("v%0d_piso_data", i), piso_data, vecs[i].e_pd);
            if (vecs[i].e_sv)
                chk($sformatf("v%0d_ser_data", i), ser_data, vecs[i].e_sd);
            tick();
        end

        // Flush during the 3rd bit, then flush beats in_valid in IDLE.
        drive(1, wa, 0, 1);
        tick();
        drive(0, '0, 0, 1);
        tick();
        tick();
        tick();
        flush = 1'b1;
        @(negedge clk);
        chk("fl_bit3_sv", ser_valid, 1'b1);
        chk("fl_bit3_sd", ser_data, 1'b1);
        tick();
        drive(1, 6'b000001, 1, 1);
        @(negedge clk);
        chk("fl_idle_ir", in_ready, 1'b1);
        chk("fl_idle_busy", busy, 1'b0);
        chk("fl_idle_sv", ser_valid, 1'b0);
        tick();
        drive(1, 6'b000001, 0, 1);
        @(negedge clk);
        chk("fl_prio_busy", busy, 1'b0);
        chk("fl_prio_pd", piso_data, wa);
        tick();
        drive(0, '0, 0, 1);
        @(negedge clk);
        chk("fl_load_up", piso_uptake, 1'b1);
        chk("fl_load_pd", piso_data, 6'b000001);
        tick();
        serial_check(6'b000001, "fl_word");

        // Async reset mid-SHIFT.
        tick();
        drive(1, wa, 0, 1);
        tick();
        drive(0, '0, 0, 1);
        tick();
        tick();
        #2;
        chk("ar_pre_sv", ser_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("ar_sv", ser_valid, 1'b0);
        chk("ar_sl", ser_last, 1'b0);
        chk("ar_en", piso_enable, 1'b0);
        chk("ar_up", piso_uptake, 1'b0);
        chk("ar_busy", busy, 1'b0);
        chk("ar_ir", in_ready, 1'b1);
        chk("ar_pd", piso_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        drive(1, wc, 0, 1);
        @(negedge clk);
        chk("ar_hs_ir", in_ready, 1'b1);
        tick();
        drive(0, '0, 0, 1);
        @(negedge clk);
        chk("ar_load_up", piso_uptake, 1'b1);
        tick();
        serial_check(wc, "ar_word");

        // GAP_CYCLES=3 instance.
        tick();
        g_in_valid = 1'b1; g_in_data = wa;
        @(negedge clk);
        chk("gap_hs_ir", g_in_ready, 1'b1);
        tick();
        g_in_valid = 1'b0;
        @(negedge clk);
        chk("gap_load_up", g_piso_uptake, 1'b1);
        tick();
        for (int b = W - 1; b >= 0; b--) begin
            @(negedge clk);
            chk("gap_sd", g_ser_data, wa[b]);
            chk("gap_sl", g_ser_last, (b == 0));
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("gap%0d_busy", k), g_busy, 1'b1);
            chk($sformatf("gap%0d_ir", k), g_in_ready, 1'b0);
            chk($sformatf("gap%0d_sv", k), g_ser_valid, 1'b0);
            chk($sformatf("gap%0d_strobes", k), {g_piso_uptake, g_piso_enable}, 2'b00);
            tick();
        end
        @(negedge clk);
        chk("gap_end_ir", g_in_ready, 1'b1);
        chk("gap_end_busy", g_busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/piso_ctrl.md
# piso_ctrl

Sequencing controller for the 6-stage parallel-in/serial-out shift chain. Accepts parallel words on a valid/ready handshake and holds each word stable on the chain's parallel inputs. Drives the chain's `uptake` (load) and `enable` (shift) strobes and frames the resulting serial stream with valid/last flags under downstream back-pressure. Sits between the word producer and the `piso` instance; the chain's `out` is returned to this block only for monitoring.

## Interface
- `W`, default 6: word width; must equal the number of stages in the attached chain.
- `GAP_CYCLES`, default 0: idle cycles inserted after each word's last bit before the next word is accepted (0..15).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  producer has a word on `in_data`.
- `in_data`  in  W  parallel word; bit W-1 is serialized first.
- `in_ready`  out  1  controller accepts a word this cycle.
- `flush`  in  1  synchronous abort; drops the word in flight.
- `piso_data`  out  W  held word; bit i drives chain input `in<i>`.
- `piso_uptake`  out  1  chain load strobe.
- `piso_enable`  out  1  chain shift strobe.
- `piso_out`  in  1  chain serial output, pass-through source.
- `ser_data`  out  1  serial bit, equal to `piso_out`.
- `ser_valid`  out  1  `ser_data` is a valid bit.
- `ser_ready`  in  1  downstream accepts `ser_data` this cycle.
- `ser_last`  out  1  current bit is the word's final (bit 0) bit.
- `busy`  out  1  state is not IDLE.

## Operation
- States: IDLE, LOAD, SHIFT, GAP.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`, capture `in_data` into `piso_data` and go to LOAD.
- LOAD:
  - `piso_uptake`=1, `piso_enable`=0 for exactly one cycle; the chain loads at this edge.
  - Clear `bit_cnt` and go to SHIFT.
- SHIFT:
  - `ser_valid`=1 and `ser_data`=`piso_out`, which equals `piso_data[W-1-bit_cnt]`.
  - `piso_enable` = `ser_ready`; `piso_uptake`=0.
  - On `ser_ready`, increment `bit_cnt`.
  - `ser_ready`=0 stalls: no shift and no count change; `ser_data` stays stable.
  - `ser_last` = (`bit_cnt`==W-1).
  - On the last beat (`ser_last` & `ser_ready`), go to GAP if `GAP_CYCLES`>0, else IDLE.
- GAP:
  - Count `GAP_CYCLES` cycles with all strobes 0, then go to IDLE.
- `bit_cnt` width is $clog2(W). It never exceeds W-1 and is not wrapped.
- The gap counter is 4 bits.
- `piso_data` holds its value from capture until the next capture; it is unchanged in IDLE.
- Zero-fill from the chain head during shifts is expected and never marked valid.
- `flush`:
  - In any state, forces IDLE at the next edge and clears the counters.
  - The chain contents are not cleared; the next LOAD overwrites them.
  - `flush` has priority over `in_valid` in IDLE: no capture occurs that cycle.
- `piso_uptake` and `piso_enable` are never both 1.

## Timing
- Reset (`rst_n`=0): state IDLE, `bit_cnt`=0, gap count=0, `piso_data`=0. Outputs: `piso_uptake`=0, `piso_enable`=0, `ser_valid`=0, `ser_last`=0, `busy`=0, `in_ready`=1.
- Reset asserted mid-word: outputs go to reset values immediately; the word is lost.
- Handshake at edge E (IDLE, `in_valid`=1):
  - LOAD during cycle E+1.
  - First `ser_valid` during cycle E+2.
- With `ser_ready` held at 1: bits appear in cycles E+2 .. E+1+W, and `ser_last` is in cycle E+1+W.
- Word period with no stalls: W+2+`GAP_CYCLES` cycles, i.e. 8 cycles for the defaults.
- `in_ready` is a pure state decode and does not depend on `in_valid`.
- `ser_valid`, `ser_last`, `piso_enable` and `ser_data` may depend combinationally on state/`ser_ready`/`piso_out`.
- No other combinational input-to-output paths.

## Test plan
- Reset, then `in_data`=6'b101100 with `ser_ready`=1 → `ser_data` = 1,0,1,1,0,0 on six consecutive cycles starting 2 cycles after the handshake. `ser_last` is on the 6th bit only, and `in_ready` returns to 1 on the next cycle.
- Same word with `ser_ready` low for 3 cycles after the 2nd bit → bit 3 (value 1) is held for 4 cycles with no `piso_enable`. The stream is otherwise identical.
- Two back-to-back words 6'h3F and 6'h15 with `in_valid` held → second handshake exactly 8 cycles after the first. Second stream is 0,1,0,1,0,1.
- `GAP_CYCLES`=3 → `in_ready` rises 4 cycles after the last beat; `busy`=1 throughout the gap.
- `flush` pulsed during the 3rd bit → IDLE next cycle, `ser_valid`=0. A following word 6'b000001 serializes correctly as 0,0,0,0,0,1.
- `rst_n` pulsed low mid-SHIFT → all outputs reach reset values without waiting for a clock edge. The next handshake operates normally.
